// File: rtl/lcd_spi_pkg.sv
// Shared opcodes, parser state encoding and pixel format for the SPI LCD receive model.
package lcd_spi_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR
    } parse_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/lcd_spi_decoder_if.sv
// 4-wire SPI LCD link plus panel reset; master drives the pins, slave observes them.
interface lcd_spi_decoder_if;
    logic lcd_resetn;
    logic lcd_clk;
    logic lcd_cs;
    logic lcd_rs;
    logic lcd_data;

    modport master (output lcd_resetn, lcd_clk, lcd_cs, lcd_rs, lcd_data);
    modport slave  (input  lcd_resetn, lcd_clk, lcd_cs, lcd_rs, lcd_data);
endinterface

// File: rtl/lcd_spi_byte_rx.sv
// Link receiver: synchronises the SPI LCD pins, detects lcd_clk rises and deserialises bytes.
// rx_* presents each assembled byte one cycle ahead of the registered byte_* outputs.
module lcd_spi_byte_rx
    import lcd_spi_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    lcd_spi_decoder_if.slave link,
    output logic             panel_rst,
    output logic             rx_done,
    output logic [7:0]       rx_byte,
    output logic             rx_is_data,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    output logic             byte_is_data
);

    localparam int SI_DAT  = 0;
    localparam int SI_RS   = 1;
    localparam int SI_CS   = 2;
    localparam int SI_CLK  = 3;
    localparam int SI_RSTN = 4;
    localparam logic [4:0] SYNC_RST = 5'b00100;

    logic [4:0] pins;
    logic [4:0] sync1_d, sync1_q, sync2_d, sync2_q;
    logic       clk_prev_d, clk_prev_q;
    logic       rise_d, rise_q;
    logic       mosi_d, mosi_q;
    logic       rs_d, rs_q;
    logic [7:0] sreg_d, sreg_q;
    logic [2:0] bit_cnt_d, bit_cnt_q;
    logic       done_d, done_q;
    logic       done_rs_d, done_rs_q;
    logic       byte_valid_d, byte_valid_q;
    logic [7:0] byte_data_d, byte_data_q;
    logic       byte_is_data_d, byte_is_data_q;

    assign pins = {link.lcd_resetn, link.lcd_clk, link.lcd_cs, link.lcd_rs, link.lcd_data};
    assign panel_rst = ~sync2_q[SI_RSTN];

    always_comb begin
        sync1_d        = pins;
        sync2_d        = sync1_q;
        clk_prev_d     = sync2_q[SI_CLK];
        // Rise is registered before shifting so data and rs travel with it through one stage.
        rise_d         = sync2_q[SI_CLK] & ~clk_prev_q & ~sync2_q[SI_CS];
        mosi_d         = sync2_q[SI_DAT];
        rs_d           = sync2_q[SI_RS];
        sreg_d         = sreg_q;
        bit_cnt_d      = bit_cnt_q;
        done_d         = 1'b0;
        done_rs_d      = done_rs_q;
        byte_valid_d   = done_q;
        byte_data_d    = byte_data_q;
        byte_is_data_d = byte_is_data_q;

        if (done_q) begin
            byte_data_d    = sreg_q;
            byte_is_data_d = done_rs_q;
        end

        if (sync2_q[SI_CS]) begin
            bit_cnt_d = 3'd0;
        end else if (rise_q) begin
            sreg_d    = {sreg_q[6:0], mosi_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                done_d    = 1'b1;
                done_rs_d = rs_q;
            end
        end

        if (panel_rst) begin
            rise_d         = 1'b0;
            sreg_d         = 8'h00;
            bit_cnt_d      = 3'd0;
            done_d         = 1'b0;
            done_rs_d      = 1'b0;
            byte_valid_d   = 1'b0;
            byte_data_d    = 8'h00;
            byte_is_data_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q        <= SYNC_RST;
            sync2_q        <= SYNC_RST;
            clk_prev_q     <= 1'b0;
            rise_q         <= 1'b0;
            mosi_q         <= 1'b0;
            rs_q           <= 1'b0;
            sreg_q         <= 8'h00;
            bit_cnt_q      <= 3'd0;
            done_q         <= 1'b0;
            done_rs_q      <= 1'b0;
            byte_valid_q   <= 1'b0;
            byte_data_q    <= 8'h00;
            byte_is_data_q <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            clk_prev_q     <= clk_prev_d;
            rise_q         <= rise_d;
            mosi_q         <= mosi_d;
            rs_q           <= rs_d;
            sreg_q         <= sreg_d;
            bit_cnt_q      <= bit_cnt_d;
            done_q         <= done_d;
            done_rs_q      <= done_rs_d;
            byte_valid_q   <= byte_valid_d;
            byte_data_q    <= byte_data_d;
            byte_is_data_q <= byte_is_data_d;
        end
    end

    assign rx_done      = done_q;
    assign rx_byte      = sreg_q;
    assign rx_is_data   = done_rs_q;
    assign byte_valid   = byte_valid_q;
    assign byte_data    = byte_data_q;
    assign byte_is_data = byte_is_data_q;

endmodule

// File: rtl/lcd_spi_decoder.sv
// ST7789-style receive model: byte receiver plus CASET/RASET/RAMWR parser emitting RGB565 pixels.
// Define LCD_DEC_STATS_EN to add frame_done and pix_count outputs.
//
// state    | meaning
// ST_IDLE  | waiting for CASET/RASET/RAMWR; stray data bytes ignored
// ST_CASET | collecting x_start/x_end (4 data bytes)
// ST_RASET | collecting y_start/y_end (4 data bytes)
// ST_RAMWR | pairing data bytes into pixels, walking the window
module lcd_spi_decoder
    import lcd_spi_pkg::*;
#(
    parameter int SCREEN_W = 240,
    parameter int SCREEN_H = 320,
    parameter int COORD_W  = 9
) (
    input  logic               clk,
    input  logic               reset,
    lcd_spi_decoder_if.slave   link,
    output logic               byte_valid,
    output logic [7:0]         byte_data,
    output logic               byte_is_data,
    output logic               cmd_valid,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_data
`ifdef LCD_DEC_STATS_EN
    ,
    output logic               frame_done,
    output logic [31:0]        pix_count
`endif
);

    localparam logic [COORD_W-1:0] X_END_RST = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_END_RST = COORD_W'(SCREEN_H - 1);

    logic               panel_rst;
    logic               rx_done;
    logic [7:0]         rx_byte;
    logic               rx_is_data;

    parse_state_t       state_d, state_q;
    logic [1:0]         idx_d, idx_q;
    logic [23:0]        coord_buf_d, coord_buf_q;
    logic [COORD_W-1:0] x_start_d, x_start_q, x_end_d, x_end_q;
    logic [COORD_W-1:0] y_start_d, y_start_q, y_end_d, y_end_q;
    logic [COORD_W-1:0] cur_x_d, cur_x_q, cur_y_d, cur_y_q;
    logic [7:0]         hi_d, hi_q;
    logic               have_hi_d, have_hi_q;
    logic               cmd_valid_d, cmd_valid_q;
    logic               pix_valid_d, pix_valid_q;
    logic [COORD_W-1:0] pix_x_d, pix_x_q, pix_y_d, pix_y_q;
    rgb565_t            pix_data_d, pix_data_q;
`ifdef LCD_DEC_STATS_EN
    logic               frame_done_d, frame_done_q;
    logic [31:0]        pix_count_d, pix_count_q;
`endif

    logic [31:0]        coord_word;
    logic               x_last, y_last;

    lcd_spi_byte_rx u_byte_rx (
        .clk          (clk),
        .reset        (reset),
        .link         (link),
        .panel_rst    (panel_rst),
        .rx_done      (rx_done),
        .rx_byte      (rx_byte),
        .rx_is_data   (rx_is_data),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_is_data (byte_is_data)
    );

    assign coord_word = {coord_buf_q, rx_byte};
    // A reversed range collapses to a single column/row at the start coordinate.
    assign x_last = (cur_x_q == x_end_q) || (x_start_q > x_end_q);
    assign y_last = (cur_y_q == y_end_q) || (y_start_q > y_end_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        coord_buf_d = coord_buf_q;
        x_start_d   = x_start_q;
        x_end_d     = x_end_q;
        y_start_d   = y_start_q;
        y_end_d     = y_end_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        hi_d        = hi_q;
        have_hi_d   = have_hi_q;
        cmd_valid_d = 1'b0;
        pix_valid_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_data_d  = pix_data_q;
`ifdef LCD_DEC_STATS_EN
        frame_done_d = 1'b0;
        pix_count_d  = pix_count_q;
`endif

        if (rx_done) begin
            if (!rx_is_data) begin
                cmd_valid_d = 1'b1;
                idx_d       = 2'd0;
                have_hi_d   = 1'b0;
                case (rx_byte)
                    CMD_CASET: state_d = ST_CASET;
                    CMD_RASET: state_d = ST_RASET;
                    CMD_RAMWR: begin
                        state_d = ST_RAMWR;
                        cur_x_d = x_start_q;
                        cur_y_d = y_start_q;
                    end
                    default:   state_d = ST_IDLE;
                endcase
            end else begin
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        coord_buf_d = {coord_buf_q[15:0], rx_byte};
                        idx_d       = idx_q + 2'd1;
                        // Window registers only change once all four bytes have arrived.
                        if (idx_q == 2'd3) begin
                            state_d = ST_IDLE;
                            if (state_q == ST_CASET) begin
                                x_start_d = coord_word[16 +: COORD_W];
                                x_end_d   = coord_word[0 +: COORD_W];
                            end else begin
                                y_start_d = coord_word[16 +: COORD_W];
                                y_end_d   = coord_word[0 +: COORD_W];
                            end
                        end
                    end
                    ST_RAMWR: begin
                        if (!have_hi_q) begin
                            hi_d      = rx_byte;
                            have_hi_d = 1'b1;
                        end else begin
                            have_hi_d   = 1'b0;
                            pix_valid_d = 1'b1;
                            pix_x_d     = cur_x_q;
                            pix_y_d     = cur_y_q;
                            pix_data_d  = rgb565_t'({hi_q, rx_byte});
`ifdef LCD_DEC_STATS_EN
                            frame_done_d = (cur_x_q == x_end_q) && (cur_y_q == y_end_q);
                            pix_count_d  = pix_count_q + 32'd1;
`endif
                            if (x_last) begin
                                cur_x_d = x_start_q;
                                cur_y_d = y_last ? y_start_q : cur_y_q + 1'b1;
                            end else begin
                                cur_x_d = cur_x_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (panel_rst) begin
            state_d     = ST_IDLE;
            idx_d       = 2'd0;
            coord_buf_d = 24'h0;
            x_start_d   = '0;
            x_end_d     = X_END_RST;
            y_start_d   = '0;
            y_end_d     = Y_END_RST;
            cur_x_d     = '0;
            cur_y_d     = '0;
            hi_d        = 8'h00;
            have_hi_d   = 1'b0;
            cmd_valid_d = 1'b0;
            pix_valid_d = 1'b0;
            pix_x_d     = '0;
            pix_y_d     = '0;
            pix_data_d  = '0;
`ifdef LCD_DEC_STATS_EN
            frame_done_d = 1'b0;
            pix_count_d  = 32'd0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            coord_buf_q <= 24'h0;
            x_start_q   <= '0;
            x_end_q     <= X_END_RST;
            y_start_q   <= '0;
            y_end_q     <= Y_END_RST;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            hi_q        <= 8'h00;
            have_hi_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_data_q  <= '0;
`ifdef LCD_DEC_STATS_EN
            frame_done_q <= 1'b0;
            pix_count_q  <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            coord_buf_q <= coord_buf_d;
            x_start_q   <= x_start_d;
            x_end_q     <= x_end_d;
            y_start_q   <= y_start_d;
            y_end_q     <= y_end_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            hi_q        <= hi_d;
            have_hi_q   <= have_hi_d;
            cmd_valid_q <= cmd_valid_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_data_q  <= pix_data_d;
`ifdef LCD_DEC_STATS_EN
            frame_done_q <= frame_done_d;
            pix_count_q  <= pix_count_d;
`endif
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_data  = pix_data_q;
`ifdef LCD_DEC_STATS_EN
    assign frame_done = frame_done_q;
    assign pix_count  = pix_count_q;
`endif

endmodule
